// File: rtl/fifo_wptr_full_pkg.sv
// rtl/fifo_wptr_full_pkg.sv - shared async FIFO pointer helpers
// Pointer sizing and Gray conversions shared by the write and read pointer blocks.
package fifo_wptr_full_pkg;

  localparam int MAX_PTR_W = 32;

  typedef logic [MAX_PTR_W-1:0] ptr_t;

  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // Operands are zero-extended to MAX_PTR_W, so leading zeros convert to leading zeros.
  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
    for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wptr_full_sync_gray_r2w.sv
// rtl/fifo_wptr_full_sync_gray_r2w.sv - multi-flop synchroniser for a Gray pointer
// Pure flop chain; no logic between stages so only Gray values cross domains.
module sync_gray_r2w #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_d [STAGES];

  always_comb begin
    sync_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_wptr_full.sv
// rtl/fifo_wptr_full.sv - async FIFO write pointer and full/occupancy flags
// Flags are computed from the next pointer against the synchronised read pointer.
module fifo_wptr_full
  import fifo_wptr_full_pkg::*;
#(
  parameter int ADDR_WIDTH         = 4,
  parameter int SYNC_STAGES        = 2,
  parameter int ALMOST_FULL_THRESH = 2
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   rgray_async,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDR_WIDTH:0]   wcount
);

  localparam int PTR_W = ptr_width(ADDR_WIDTH);
  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam logic [PTR_W-1:0] DEPTH_P  = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] THRESH_P = PTR_W'(ALMOST_FULL_THRESH);

  logic [PTR_W-1:0] wbin_q, wbin_d;
  logic [PTR_W-1:0] wgray_q, wgray_d;
  logic [PTR_W-1:0] wcount_q, wcount_d;
  logic             wfull_q, wfull_d;
  logic             walmost_full_q, walmost_full_d;
  logic [PTR_W-1:0] rq_gray;
  logic [PTR_W-1:0] rbin_sync;
  logic [PTR_W-1:0] full_target;
  logic [PTR_W-1:0] free_slots;

  sync_gray_r2w #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_sync_r2w (
    .clk (wclk),
    .rst (wrst),
    .d   (rgray_async),
    .q   (rq_gray)
  );

  always_comb begin
    wen            = winc & ~wfull_q & ~wrst;
    wbin_d         = wbin_q + PTR_W'(wen);
    wgray_d        = PTR_W'(bin2gray(32'(wbin_d)));
    rbin_sync      = PTR_W'(gray2bin(32'(rq_gray)));
    // Full when the write pointer is one lap ahead: top two Gray bits inverted.
    full_target    = {~rq_gray[PTR_W-1:PTR_W-2], rq_gray[PTR_W-3:0]};
    wfull_d        = (wgray_d == full_target);
    wcount_d       = wbin_d - rbin_sync;
    free_slots     = DEPTH_P - wcount_d;
    walmost_full_d = (free_slots <= THRESH_P);
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin_q         <= '0;
      wgray_q        <= '0;
      wcount_q       <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
    end else begin
      wbin_q         <= wbin_d;
      wgray_q        <= wgray_d;
      wcount_q       <= wcount_d;
      wfull_q        <= wfull_d;
      walmost_full_q <= walmost_full_d;
    end
  end

  assign waddr        = wbin_q[ADDR_WIDTH-1:0];
  assign wptr_gray    = wgray_q;
  assign wfull        = wfull_q;
  assign walmost_full = walmost_full_q;
  assign wcount       = wcount_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// tb/tb_fifo_wptr_full.sv - self-checking bench for fifo_wptr_full
// Integer occupancy model feeds a scoreboard of expected post-edge outputs.
module tb_fifo_wptr_full;

  logic       wclk = 1'b0;
  logic       wrst = 1'b1;
  logic       winc = 1'b0;
  logic [4:0] rgray_async = '0;
  logic       wen;
  logic [3:0] waddr;
  logic [4:0] wptr_gray;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wcount;

  fifo_wptr_full #(
    .ADDR_WIDTH         (4),
    .SYNC_STAGES        (2),
    .ALMOST_FULL_THRESH (2)
  ) dut (
    .wclk         (wclk),
    .wrst         (wrst),
    .winc         (winc),
    .rgray_async  (rgray_async),
    .wen          (wen),
    .waddr        (waddr),
    .wptr_gray    (wptr_gray),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wcount       (wcount)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    logic [4:0] gray;
    logic       full;
    logic       af;
    int         cnt;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  int   m_wr, s0, s1;
  logic m_full;
  int   hist[$];
  bit   saw_full;

  task automatic check_val(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] to_gray(input int b);
    logic [4:0] x;
    x = b[4:0];
    return x ^ (x >> 1);
  endfunction

  task automatic model_clear();
    m_wr = 0; s0 = 0; s1 = 0; m_full = 1'b0;
    sb.delete();
  endtask

  // One write-clock cycle: inputs applied just after an edge, outputs checked after the next.
  task automatic step(input logic w, input int rd);
    exp_t e;
    int   cnt;
    logic acc;
    winc = w;
    rgray_async = to_gray(rd);
    @(negedge wclk);
    acc = w && !m_full;
    check_val("wen", int'(wen), int'(acc));
    check_val("waddr", int'(waddr), m_wr % 16);
    m_wr  = m_wr + int'(acc);
    cnt   = m_wr - s1;
    m_full = (cnt == 16);
    e.gray = to_gray(m_wr);
    e.full = m_full;
    e.af   = ((16 - cnt) <= 2);
    e.cnt  = cnt;
    sb.push_back(e);
    s1 = s0;
    s0 = rd;
    @(posedge wclk);
    #1;
    e = sb.pop_front();
    check_val("wptr_gray", int'(wptr_gray), int'(e.gray));
    check_val("wfull", int'(wfull), int'(e.full));
    check_val("walmost_full", int'(walmost_full), int'(e.af));
    check_val("wcount", int'(wcount), e.cnt);
    if (wfull) saw_full = 1'b1;
  endtask

  task automatic do_reset();
    winc = 1'b0;
    rgray_async = '0;
    wrst = 1'b1;
    model_clear();
    repeat (2) @(posedge wclk);
    @(negedge wclk);
    wrst = 1'b0;
    @(posedge wclk);
    #1;
  endtask

  initial begin
    // Reset state
    winc = 1'b0;
    #3;
    check_val("rst_wen", int'(wen), 0);
    check_val("rst_waddr", int'(waddr), 0);
    check_val("rst_gray", int'(wptr_gray), 0);
    check_val("rst_full", int'(wfull), 0);
    check_val("rst_af", int'(walmost_full), 0);
    check_val("rst_count", int'(wcount), 0);
    do_reset();

    // Fill to full, then one dropped request
    for (int i = 0; i < 16; i++) step(1'b1, 0);
    check_val("fill_gray", int'(wptr_gray), 5'b11000);
    check_val("fill_full", int'(wfull), 1);
    check_val("fill_count", int'(wcount), 16);
    step(1'b1, 0);
    check_val("fill_hold_gray", int'(wptr_gray), 5'b11000);

    // Release after one read: clears on the third edge
    step(1'b0, 1);
    step(1'b0, 1);
    check_val("rel_still_full", int'(wfull), 1);
    step(1'b0, 1);
    check_val("rel_full_clear", int'(wfull), 0);
    check_val("rel_count", int'(wcount), 15);
    check_val("rel_waddr", int'(waddr), 0);
    step(1'b1, 1);

    // Almost-full threshold
    do_reset();
    for (int i = 0; i < 13; i++) step(1'b1, 0);
    check_val("af13", int'(walmost_full), 0);
    check_val("af13_count", int'(wcount), 13);
    step(1'b1, 0);
    check_val("af14", int'(walmost_full), 1);
    check_val("af14_count", int'(wcount), 14);

    // Write and read-pointer advance in the same cycle
    do_reset();
    for (int i = 0; i < 15; i++) step(1'b1, 0);
    step(1'b1, 1);
    check_val("sim_full", int'(wfull), 1);
    step(1'b0, 1);
    step(1'b0, 1);
    check_val("sim_clear", int'(wfull), 0);
    check_val("sim_count", int'(wcount), 15);

    // Long stream across the pointer wrap with a lagging reader
    do_reset();
    hist.delete();
    saw_full = 1'b0;
    for (int i = 0; i < 40; i++) begin
      hist.push_back(m_wr);
      step(1'b1, (hist.size() > 4) ? hist[hist.size()-5] : 0);
    end
    check_val("wrap_no_full", int'(saw_full), 0);
    check_val("wrap_gray", int'(wptr_gray), int'(to_gray(40)));

    // Asynchronous reset mid-operation
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 0);
    winc = 1'b1;
    #2;
    wrst = 1'b1;
    #1;
    check_val("mid_wen", int'(wen), 0);
    check_val("mid_waddr", int'(waddr), 0);
    check_val("mid_gray", int'(wptr_gray), 0);
    check_val("mid_count", int'(wcount), 0);
    check_val("mid_full", int'(wfull), 0);
    check_val("mid_af", int'(walmost_full), 0);
    model_clear();
    winc = 1'b0;
    @(negedge wclk);
    wrst = 1'b0;
    @(posedge wclk);
    #1;
    check_val("post_rst_waddr", int'(waddr), 0);
    step(1'b1, 0);
    check_val("post_rst_waddr1", int'(waddr), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wptr_full.md
Name: fifo_wptr_full

Overview:
- Write-side control stage of the async FIFO.
- Accepts write requests from the producer and generates the write enable and write address for the dual-port FIFO memory.
- Maintains the binary and Gray write pointers and synchronises the read-domain Gray pointer into wclk.
- Produces registered full, almost-full and occupancy outputs for the producer.

Parameters:
- ADDR_WIDTH, 4: memory address width; DEPTH = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits. Legal range is at least 2.
- SYNC_STAGES, 2: flop stages in the read-to-write Gray pointer synchroniser. Legal range is at least 2.
- ALMOST_FULL_THRESH, 2: walmost_full asserts when free slots are at most this value. Legal range is 1 to DEPTH-1.

Ports:
- wclk  in  1  write-domain clock
- wrst  in  1  asynchronous, active-high reset (wrst), clears all state
- winc  in  1  producer write request, level, one word per cycle
- rgray_async  in  ADDR_WIDTH+1  read pointer, Gray-coded, registered in the read domain, asynchronous to wclk
- wen  out  1  memory write enable, equals winc AND NOT wfull (combinational)
- waddr  out  ADDR_WIDTH  memory write address, equals wbin[ADDR_WIDTH-1:0]
- wptr_gray  out  ADDR_WIDTH+1  registered Gray write pointer, sent to the read-side synchroniser
- wfull  out  1  registered full flag
- walmost_full  out  1  registered almost-full flag
- wcount  out  ADDR_WIDTH+1  registered occupancy as seen from the write side, range 0 to DEPTH

Behaviour:
- Reset: wrst asynchronously clears wbin, wptr_gray, all synchroniser flops, wfull, walmost_full and wcount to 0. wen is therefore 0 and waddr is 0. Reset mid-operation takes effect immediately, without waiting for a clock edge. The read side must be reset in the same reset window; this is a system-level requirement.
- Handshake: a write is accepted in any cycle where winc=1 and wfull=0. wdata must be valid that cycle, and the memory captures it on the same wclk edge. winc while wfull=1 is dropped silently; the pointer holds.
- Pointer update each edge:
  - wbin_next = wbin + wen, modulo 2^(ADDR_WIDTH+1).
  - wgray_next = wbin_next XOR (wbin_next >> 1).
  - wbin <= wbin_next; wptr_gray <= wgray_next.
- Synchroniser: rgray_async passes through SYNC_STAGES flops to give rq_gray. No logic is allowed between the stages. Only Gray-coded values cross the domain boundary.
- Full: wfull <= (wgray_next == {~rq_gray[MSB:MSB-1], rq_gray[MSB-2:0]}).
  - Asserts on the edge that accepts the DEPTH-th outstanding word, with zero latency.
  - Deassertion is pessimistic: it occurs SYNC_STAGES+1 edges after rgray_async changes.
- Occupancy:
  - rbin_sync = gray-to-binary of rq_gray, combinational.
  - wcount <= wbin_next - rbin_sync, modulo 2^(ADDR_WIDTH+1).
  - walmost_full <= (DEPTH - (wbin_next - rbin_sync)) <= ALMOST_FULL_THRESH.
  - Both outputs update on the same edge as wfull.
- Wrap-around: wbin wraps from 2^(ADDR_WIDTH+1)-1 to 0. The extra MSB distinguishes full from empty. Behaviour is continuous across the wrap with no spurious full.
- Simultaneous write and read-pointer advance: the write is accepted and flags are computed against the stale synchronised pointer, i.e. conservatively. They correct themselves after the synchroniser latency.
- Overflow of the memory is impossible by construction. Underflow is the read side's concern.

Decomposition:
- Shared async-FIFO package holds:
  - pointer width constant PTR_W = ADDR_WIDTH+1
  - DEPTH derivation
  - bin2gray and gray2bin functions, reused by the read-side pointer block
- One sub-module: sync_gray_r2w, a parameterised width × SYNC_STAGES flop chain on wclk/wrst. It is reused mirror-wise as sync_gray_w2r on the read side.

Test Plan (ADDR_WIDTH=4, SYNC_STAGES=2, ALMOST_FULL_THRESH=2):
- Fill: reset, rgray_async=0, winc=1 for 17 cycles.
  - waddr steps 0..15 with wen=1.
  - wfull=1 after the 16th edge, wptr_gray=5'b11000, wcount=16.
  - On the 17th cycle wen=0 and wptr_gray is unchanged.
- Almost-full: from reset, perform 13 writes, then a 14th.
  - walmost_full=0 and wcount=13 after the 13th.
  - walmost_full=1 and wcount=14 after the 14th.
- Full release: when full, set rgray_async=5'b00001 (read of 1 word).
  - wfull stays 1 for 2 edges and clears on the 3rd edge; wcount=15 on that edge.
  - The next winc is accepted at waddr=0.
- Wrap: stream 40 writes with rgray_async tracking wptr_gray delayed 4 cycles.
  - wbin wraps 31→0 and wptr_gray goes 5'b10000→5'b00000.
  - wfull never asserts; waddr sequence is continuous modulo 16.
- Reset mid-operation: after 7 writes, assert wrst between edges with winc=1.
  - wen, waddr, wptr_gray, wcount, wfull and walmost_full all read 0 before the next wclk edge.
  - After release, the first write goes to waddr=0.
- Simultaneous: at wcount=15, assert winc and advance rgray_async to gray(1) in the same cycle.
  - The write is accepted and wfull=1.
  - wfull clears 3 edges after the rgray_async change, with wcount=15.
